mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl_if.sv | 31 +++
 rtl/mem_req_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_if.sv
// Request/response and memory-bus bundle for mem_req_ctrl.
//   Cache side : req_valid, req_we, req_addr, req_wdata -> req_ready
//                rsp_valid, rsp_rdata (read responses), wb_empty (buffer status)
//   Memory side: addr, wdata, memread, memwrite -> rdata, mem_done
// modport slave is the controller; modport master is the environment (cache + memory).
interface mem_req_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        wb_empty;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        memread;
    logic        memwrite;
    logic [15:0] rdata;
    logic        mem_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rdata, mem_done,
        input  req_ready, rsp_valid, rsp_rdata, wb_empty, addr, wdata, memread, memwrite
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rdata, mem_done,
        output req_ready, rsp_valid, rsp_rdata, wb_empty, addr, wdata, memread, memwrite
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Memory request controller with a FIFO write buffer.
// Writes are posted into a WB_DEPTH-entry buffer and drained to memory in order;
// reads are served from the buffer on a hit (youngest entry wins) or from memory
// on a miss.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - mem_req_ctrl_if.slave: cache request/response and memory bus
module mem_req_ctrl #(
    parameter int unsigned WB_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    mem_req_ctrl_if.slave bus
);

    localparam int unsigned PtrW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(WB_DEPTH);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrIssue} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [4:0]      wb_addr_q [WB_DEPTH];
    logic [15:0]     wb_data_q [WB_DEPTH];

    logic [4:0]      addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            memread_q, memread_d;
    logic            memwrite_q, memwrite_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_rdata_q, rsp_rdata_d;

    logic            full, req_ready, rd_acc, wr_acc, push, pop, hit;
    logic [15:0]     hit_data;
    logic [PtrW-1:0] idx;

    // A full buffer blocks reads as well as writes so the drain can win.
    assign full      = (count_q == DepthCnt);
    assign req_ready = !rst && (state_q == StIdle) && !full;
    assign rd_acc    = bus.req_valid && req_ready && !bus.req_we;
    assign wr_acc    = bus.req_valid && req_ready && bus.req_we;

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if ((CntW'(i) < count_q) && (wb_addr_q[idx] == bus.req_addr)) begin
                hit      = 1'b1;
                hit_data = wb_data_q[idx];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        memread_d   = memread_q;
        memwrite_d  = memwrite_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        push        = 1'b0;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                push = wr_acc;
                if (rd_acc) begin
                    if (hit) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = hit_data;
                    end else begin
                        state_d   = StRdWait;
                        addr_d    = bus.req_addr;
                        memread_d = 1'b1;
                    end
                end else if (!wr_acc && (count_q != '0)) begin
                    // Drain only on an edge with no accepted request, so a write
                    // burst can fill the buffer before memory is touched.
                    state_d    = StWrIssue;
                    memwrite_d = 1'b1;
                    addr_d     = wb_addr_q[head_q];
                    wdata_d    = wb_data_q[head_q];
                end
            end
            StRdWait: begin
                if (bus.mem_done) begin
                    state_d     = StIdle;
                    memread_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.rdata;
                end
            end
            StWrIssue: begin
                if (bus.mem_done) begin
                    state_d    = StIdle;
                    memwrite_d = 1'b0;
                    pop        = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        head_d = pop  ? head_q + 1'b1 : head_q;
        tail_d = push ? tail_q + 1'b1 : tail_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Entry storage needs no reset: validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[tail_q] <= bus.req_addr;
            wb_data_q[tail_q] <= bus.req_wdata;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.wb_empty  = (count_q == '0);
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.memread   = memread_q;
    assign bus.memwrite  = memwrite_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl with a scoreboard for read data and
// write order, and a memory model whose reads complete after 11 memread cycles.
module tb_mem_req_ctrl;
    localparam int unsigned WB_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_req_ctrl_if bus ();

    mem_req_ctrl #(.WB_DEPTH(WB_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory model: word a holds {2a+1, 2a} until written.
    logic [15:0] mem     [32];
    logic [15:0] ref_mem [32];
    bit          mem_ready = 1'b0;
    int          rd_cnt    = 0;

    assign bus.rdata    = mem[bus.addr];
    assign bus.mem_done = bus.memwrite | (bus.memread & (rd_cnt == 10));

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 32; a++) mem[a] <= {8'(2 * a + 1), 8'(2 * a)};
            mem_ready <= 1'b1;
        end else if (bus.memwrite === 1'b1) begin
            mem[bus.addr] <= bus.wdata;
        end
        if (bus.memread !== 1'b1 || bus.mem_done === 1'b1) rd_cnt <= 0;
        else rd_cnt <= rd_cnt + 1;
    end

    logic [15:0] rexp [$];
    logic [20:0] wexp [$];

    // Scoreboard and protocol monitor, sampled on the falling edge.
    initial begin
        logic [15:0] er;
        logic [20:0] ew;
        logic        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (bus.memread === 1'b1 && bus.memwrite === 1'b1) begin
                    errors++;
                    $display("FAIL strobe_overlap: memread=%b memwrite=%b want not both", bus.memread, bus.memwrite);
                end
                if (prev_rd && bus.memread !== 1'b1) begin
                    checks++;
                    if (bus.memwrite !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_after_read: memwrite=%b want 0", bus.memwrite);
                    end
                end
                if (bus.rsp_valid === 1'b1) begin
                    checks++;
                    if (rexp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp: got data %h want no response", bus.rsp_rdata);
                    end else begin
                        er = rexp.pop_front();
                        if (bus.rsp_rdata !== er) begin
                            errors++;
                            $display("FAIL rsp_data: got %h want %h", bus.rsp_rdata, er);
                        end
                    end
                end
                if (bus.memwrite === 1'b1 && bus.mem_done === 1'b1) begin
                    checks++;
                    if (wexp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: got %h:%h want none", bus.addr, bus.wdata);
                    end else begin
                        ew = wexp.pop_front();
                        if ({bus.addr, bus.wdata} !== ew) begin
                            errors++;
                            $display("FAIL write_order: got %h:%h want %h:%h", bus.addr, bus.wdata, ew[20:16], ew[15:0]);
                        end
                    end
                end
                if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
                    if (bus.req_we) begin
                        wexp.push_back({bus.req_addr, bus.req_wdata});
                        ref_mem[bus.req_addr] = bus.req_wdata;
                    end else begin
                        rexp.push_back(ref_mem[bus.req_addr]);
                    end
                end
            end
            prev_rd = (bus.memread === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "bench timeout");
    end

    task automatic send(input logic we, input logic [4:0] a, input logic [15:0] d);
        bit ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: addr %h never accepted, want accept within 100 cycles", a);
        end
    endtask

    task automatic wait_empty();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.wb_empty === 1'b1 && bus.memwrite === 1'b0 && bus.memread === 1'b0 &&
                rexp.size() == 0 && wexp.size() == 0) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain: wb_empty=%b pending_rd=%0d pending_wr=%0d want empty", bus.wb_empty, rexp.size(), wexp.size());
        end
    endtask

    task automatic wait_rsp(output logic [15:0] d, output int lat);
        lat = -1;
        d   = '0;
        for (int j = 0; j < 60 && lat < 0; j++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                lat = j;
                d   = bus.rsp_rdata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sync_ref();
        for (int a = 0; a < 32; a++) ref_mem[a] = mem[a];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 5'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        checks++; if (bus.memread !== 1'b0) begin errors++; $display("FAIL reset_memread: got %b want 0", bus.memread); end
        checks++; if (bus.memwrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite: got %b want 0", bus.memwrite); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.addr !== 5'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.addr); end
        checks++; if (bus.wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.wdata); end
        checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL reset_wb_empty: got %b want 1", bus.wb_empty); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        rexp.delete();
        wexp.delete();
        sync_ref();
    endtask

    task automatic test_read_miss();
        int          rd_cycles = 0;
        int          lat       = -1;
        logic [15:0] got       = '0;
        checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL miss_pre_empty: got %b want 1", bus.wb_empty); end
        send(1'b0, 5'd5, 16'h0);
        for (int j = 0; j < 40 && lat < 0; j++) begin
            @(negedge clk);
            if (bus.memread === 1'b1) rd_cycles++;
            if (bus.rsp_valid === 1'b1) begin
                lat = j;
                got = bus.rsp_rdata;
            end
        end
        checks++; if (lat != 11) begin errors++; $display("FAIL miss_latency: got %0d want 11", lat); end
        checks++; if (rd_cycles != 11) begin errors++; $display("FAIL miss_memread_cycles: got %0d want 11", rd_cycles); end
        checks++; if (got !== 16'h0B0A) begin errors++; $display("FAIL miss_data: got %h want 0b0a", got); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL miss_single_pulse: got %b want 0", bus.rsp_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hit();
        int rd_seen = 0;
        wait_empty();
        send(1'b1, 5'd3, 16'h1234);
        send(1'b0, 5'd3, 16'h0);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL hit_rsp_valid: got %b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'h1234) begin errors++; $display("FAIL hit_data: got %h want 1234", bus.rsp_rdata); end
        for (int j = 0; j < 15; j++) begin
            if (bus.memread === 1'b1) rd_seen++;
            @(negedge clk);
        end
        checks++; if (rd_seen != 0) begin errors++; $display("FAIL hit_no_memread: got %0d cycles want 0", rd_seen); end
        @(posedge clk);
        #1;
        wait_empty();
    endtask

    task automatic test_back_to_back();
        wait_empty();
        for (int i = 0; i < 4; i++) send(1'b1, 5'(10 + i), 16'hA000 + 16'(i));
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 5'd14;
        bus.req_wdata = 16'hA004;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready: got %b want 0", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.memwrite !== 1'b1) begin errors++; $display("FAIL full_drain_wins: memwrite=%b want 1", bus.memwrite); end
        checks++; if (bus.addr !== 5'd10) begin errors++; $display("FAIL full_drain_head: addr=%h want 0a", bus.addr); end
        @(posedge clk);
        #1;
        send(1'b1, 5'd14, 16'hA004);
        wait_empty();
    endtask

    task automatic test_youngest();
        wait_empty();
        send(1'b1, 5'd7, 16'h1111);
        send(1'b1, 5'd7, 16'h2222);
        send(1'b0, 5'd7, 16'h0);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL youngest_valid: got %b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'h2222) begin errors++; $display("FAIL youngest_data: got %h want 2222", bus.rsp_rdata); end
        @(posedge clk);
        #1;
        wait_empty();
    endtask

    task automatic test_reset_rd_wait();
        logic [15:0] d;
        int          lat;
        int          stray = 0;
        wait_empty();
        send(1'b1, 5'd21, 16'hBEEF);
        send(1'b0, 5'd20, 16'h0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        rexp.delete();
        wexp.delete();
        @(negedge clk);
        checks++; if (bus.memread !== 1'b0) begin errors++; $display("FAIL rst_rd_memread: got %b want 0", bus.memread); end
        checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL rst_rd_wb_empty: got %b want 1", bus.wb_empty); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_rd_req_ready: got %b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sync_ref();
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_rd_no_rsp: got %0d pulses want 0", stray); end
        @(posedge clk);
        #1;
        send(1'b0, 5'd5, 16'h0);
        wait_rsp(d, lat);
        checks++; if (d !== 16'h0B0A || lat != 11) begin errors++; $display("FAIL rst_rd_reread: got %h lat %0d want 0b0a lat 11", d, lat); end
        send(1'b0, 5'd21, 16'h0);
        wait_rsp(d, lat);
        checks++; if (d !== 16'h2B2A) begin errors++; $display("FAIL rst_rd_discard: got %h want 2b2a", d); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 16'($urandom));
        end
        wait_empty();
        checks++; if (bus.wb_empty !== 1'b1) begin errors++; $display("FAIL random_final_empty: got %b want 1", bus.wb_empty); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_read_miss();
        test_hit();
        test_back_to_back();
        test_youngest();
        test_reset_rd_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
